// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that serialises four requesters onto one binary-to-Gray
// converter and presents each result on a valid/ready port tagged with its owner.
module gray_conv_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req,
   input  logic [4*WIDTH-1:0]   b_in,
   output logic [3:0]           gnt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     g,
   output logic [1:0]           out_id,
   output logic                 busy,
   output logic [7:0]           xfer_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      OUT  = 2'd2
   } state_e;

   state_e             state_q,     state_d;
   logic [1:0]         last_id_q,   last_id_d;
   logic [1:0]         id_lat_q,    id_lat_d;
   logic [WIDTH-1:0]   b_lat_q,     b_lat_d;
   logic [3:0]         gnt_q,       gnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   g_q,         g_d;
   logic [1:0]         out_id_q,    out_id_d;
   logic [7:0]         xfer_cnt_q,  xfer_cnt_d;

   logic               win_found;
   logic [1:0]         win_id;
   logic [1:0]         cand;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Search starts one past the last winner; an offset of 4 wraps back onto last_id itself.
   always_comb begin
      win_found = 1'b0;
      win_id    = last_id_q;
      cand      = last_id_q;
      for (int k = 1; k <= 4; k++) begin
         cand = last_id_q + k[1:0];
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      last_id_d   = last_id_q;
      id_lat_d    = id_lat_q;
      b_lat_d     = b_lat_q;
      gnt_d       = 4'b0000;
      out_valid_d = out_valid_q;
      g_d         = g_q;
      out_id_d    = out_id_q;
      xfer_cnt_d  = xfer_cnt_q;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               b_lat_d   = b_in[win_id*WIDTH +: WIDTH];
               id_lat_d  = win_id;
               last_id_d = win_id;
               gnt_d     = 4'b0001 << win_id;
               state_d   = CONV;
            end
         end
         CONV: begin
            g_d         = to_gray(b_lat_q);
            out_id_d    = id_lat_q;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               xfer_cnt_d  = xfer_cnt_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_id_q   <= 2'd3;
         id_lat_q    <= 2'd0;
         gnt_q       <= 4'b0000;
         out_valid_q <= 1'b0;
         g_q         <= '0;
         out_id_q    <= 2'd0;
         xfer_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         last_id_q   <= last_id_d;
         id_lat_q    <= id_lat_d;
         gnt_q       <= gnt_d;
         out_valid_q <= out_valid_d;
         g_q         <= g_d;
         out_id_q    <= out_id_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   // NOTE: the latched operand is pure datapath, always loaded before it is read, so it carries no reset.
   always_ff @(posedge clk) begin
      b_lat_q <= b_lat_d;
   end

   assign gnt       = gnt_q;
   assign out_valid = out_valid_q;
   assign g         = g_q;
   assign out_id    = out_id_q;
   assign busy      = (state_q != IDLE);
   assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: stimulus queues expected grants and
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_gray_conv_arbiter;

   localparam int WIDTH = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         req;
   logic [4*WIDTH-1:0] b_in;
   logic [3:0]         gnt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   g;
   logic [1:0]         out_id;
   logic               busy;
   logic [7:0]         xfer_cnt;

   gray_conv_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .b_in      (b_in),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .g         (g),
      .out_id    (out_id),
      .busy      (busy),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] g;
   } res_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   exp_gnt_q[$];
   res_t exp_res_q[$];

   logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: grants and completed handshakes are compared against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != 4'b0000) begin
            if (exp_gnt_q.size() == 0) begin
               check("sb_gnt_unexpected", gnt, 0);
            end else begin
               int e;
               e = exp_gnt_q.pop_front();
               check("sb_gnt", gnt, 32'd1 << e);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_res_q.size() == 0) begin
               check("sb_res_unexpected", {out_id, g}, 0);
            end else begin
               res_t r;
               r = exp_res_q.pop_front();
               check("sb_g", g, r.g);
               check("sb_id", out_id, r.id);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output logic [3:0] seen, output int n);
      seen = 4'b0000;
      n    = 0;
      while (n < 20 && seen == 4'b0000) begin
         tick();
         n++;
         seen = gnt;
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check(name, busy, 0);
   endtask

   task automatic do_xfer(input int id, input logic [3:0] b, input logic [3:0] eg);
      logic [3:0] seen;
      int         n;
      res_t       r;
      b_in[id*4 +: 4] = b;
      req[id]         = 1'b1;
      r.id            = id[1:0];
      r.g             = eg;
      exp_gnt_q.push_back(id);
      exp_res_q.push_back(r);
      wait_gnt(seen, n);
      check("xfer_gnt", seen, 32'd1 << id);
      req[id] = 1'b0;
      wait_idle("xfer_idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [3:0] seen;
      int         n;
      int         last_cyc;
      res_t       r;
      logic [3:0] t2_g [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};

      rst       = 1'b1;
      req       = 4'b0000;
      b_in      = '0;
      out_ready = 1'b0;

      // Reset then single request from requester 2
      repeat (2) begin
         tick();
         check("rst_gnt", gnt, 0);
         check("rst_valid", out_valid, 0);
         check("rst_g", g, 0);
         check("rst_id", out_id, 0);
         check("rst_busy", busy, 0);
         check("rst_cnt", xfer_cnt, 0);
      end
      rst          = 1'b0;
      b_in[11:8]   = 4'b1011;
      req          = 4'b0100;
      out_ready    = 1'b1;
      exp_gnt_q.push_back(2);
      r.id = 2'd2; r.g = 4'b1110;
      exp_res_q.push_back(r);
      wait_gnt(seen, n);
      check("t1_gnt", seen, 4'b0100);
      check("t1_gnt_latency", n, 1);
      req = 4'b0000;
      tick();
      check("t1_gnt_pulse", gnt, 0);
      check("t1_valid", out_valid, 1);
      check("t1_g", g, 4'b1110);
      check("t1_id", out_id, 2);
      check("t1_busy", busy, 1);
      tick();
      check("t1_cnt", xfer_cnt, 1);
      check("t1_valid_clr", out_valid, 0);
      check("t1_busy_clr", busy, 0);

      // All four at once after a fresh reset
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      b_in = {4'b0011, 4'b0010, 4'b0001, 4'b0000};
      req  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         exp_gnt_q.push_back(k);
         r.id = k[1:0]; r.g = t2_g[k];
         exp_res_q.push_back(r);
      end
      last_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(seen, n);
         check("t2_gnt", seen, 32'd1 << k);
         if (k > 0) check("t2_spacing", cyc - last_cyc, 3);
         last_cyc = cyc;
         req[k] = 1'b0;
      end
      wait_idle("t2_idle");
      check("t2_cnt", xfer_cnt, 4);

      // Backpressure with requester 3 waiting
      b_in[7:4]   = 4'b0110;
      b_in[15:12] = 4'b1000;
      out_ready   = 1'b0;
      req         = 4'b1010;
      exp_gnt_q.push_back(1);
      r.id = 2'd1; r.g = 4'b0101;
      exp_res_q.push_back(r);
      wait_gnt(seen, n);
      check("t3_gnt1", seen, 4'b0010);
      req[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_hold_valid", out_valid, 1);
         check("t3_hold_g", g, 4'b0101);
         check("t3_hold_id", out_id, 1);
         check("t3_hold_gnt", gnt, 0);
      end
      exp_gnt_q.push_back(3);
      r.id = 2'd3; r.g = 4'b1100;
      exp_res_q.push_back(r);
      out_ready = 1'b1;
      wait_gnt(seen, n);
      check("t3_gnt3", seen, 4'b1000);
      check("t3_gnt3_delay", n, 2);
      req[3] = 1'b0;
      wait_idle("t3_idle");
      check("t3_cnt", xfer_cnt, 6);

      // Fairness between requesters 0 and 1
      b_in = {4'b1111, 4'b1111, 4'b1111, 4'b0101};
      req  = 4'b0011;
      for (int k = 0; k < 6; k++) begin
         exp_gnt_q.push_back(k % 2);
         r.id = (k % 2 == 0) ? 2'd0 : 2'd1;
         r.g  = (k % 2 == 0) ? 4'b0111 : 4'b1000;
         exp_res_q.push_back(r);
      end
      for (int k = 0; k < 6; k++) begin
         wait_gnt(seen, n);
         check("t4_gnt", seen, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      end
      req = 4'b0000;
      wait_idle("t4_idle");
      check("t4_cnt", xfer_cnt, 12);

      // Reset while holding a result in OUT
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) do_xfer(2, 4'b0111, 4'b0100);
      check("t5_cnt5", xfer_cnt, 5);
      out_ready = 1'b0;
      req[2]    = 1'b1;
      exp_gnt_q.push_back(2);
      wait_gnt(seen, n);
      check("t5_gnt", seen, 4'b0100);
      req[2] = 1'b0;
      tick();
      check("t5_in_out", out_valid, 1);
      rst       = 1'b1;
      req       = 4'b1010;
      b_in[7:4] = 4'b1001;
      tick();
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_cnt", xfer_cnt, 0);
      check("t5_rst_gnt", gnt, 0);
      rst       = 1'b0;
      out_ready = 1'b1;
      exp_gnt_q.push_back(1);
      r.id = 2'd1; r.g = 4'b1101;
      exp_res_q.push_back(r);
      wait_gnt(seen, n);
      check("t5_next_gnt", seen, 4'b0010);
      req = 4'b0000;
      wait_idle("t5_idle");
      check("t5_cnt1", xfer_cnt, 1);

      // Counter wrap over 256 transfers
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 256; k++) begin
         do_xfer(k % 4, k[3:0], gray_tab[k % 16]);
         if (k == 254) check("t6_cnt255", xfer_cnt, 255);
         if (k == 255) check("t6_cnt_wrap", xfer_cnt, 0);
      end

      repeat (2) tick();
      check("sb_gnt_drained", exp_gnt_q.size(), 0);
      check("sb_res_drained", exp_res_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
